// File: rtl/qam_stream_scheduler.sv
// Gearbox and frame sequencer: packs IN_W-bit input words into FORMAT*N-bit clusters
// for the parallel QAM mapper, zero-pads the frame tail and tracks the mapper's last point.
module qam_stream_scheduler #(
  parameter int unsigned N         = 16,
  parameter int unsigned W         = 16,
  parameter int unsigned FORMAT    = 4,
  parameter int unsigned IN_W      = 32,
  parameter logic [W-1:0] LAST_INIT = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_W-1:0]      in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [FORMAT*N-1:0]  out_data,
  output logic                 out_valid,
  output logic                 out_last,
  input  logic                 out_ready,
  input  logic [W-1:0]         fb_pt,
  output logic [W-1:0]         last_pt,
  output logic [15:0]          clus_cnt
);

  localparam int unsigned CW   = FORMAT * N;
  localparam int unsigned BUF  = CW + IN_W;
  localparam int unsigned CntW = $clog2(BUF + 1);
  localparam logic [CntW-1:0] CwCnt = CntW'(CW);
  localparam logic [CntW-1:0] InCnt = CntW'(IN_W);

  if ((FORMAT < 3) || (FORMAT > 6) || (IN_W < 1) || (IN_W > CW)) begin : gen_param_err
    $error("qam_stream_scheduler: unsupported FORMAT or IN_W");
  end

  typedef enum logic [1:0] {StIdle, StFill, StFlush} state_e;

  state_e          state_q, state_d;
  logic [BUF-1:0]  buf_q, buf_d, buf_after;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_after;
  logic [W-1:0]    last_pt_q, last_pt_d;
  logic [15:0]     clus_cnt_q, clus_cnt_d;
  logic            accept, emit;

  assign in_ready  = (state_q != StFlush) && (cnt_q <= CwCnt);
  assign out_valid = (cnt_q >= CwCnt) || ((state_q == StFlush) && (cnt_q != '0));
  assign out_last  = (state_q == StFlush) && (cnt_q <= CwCnt);
  // Bits at or above cnt are always zero, so the tail cluster is already padded.
  assign out_data  = buf_q[CW-1:0];
  assign last_pt   = last_pt_q;
  assign clus_cnt  = clus_cnt_q;

  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

  always_comb begin
    buf_after = buf_q;
    cnt_after = cnt_q;
    if (emit) begin
      buf_after = buf_q >> CW;
      cnt_after = (cnt_q >= CwCnt) ? cnt_q - CwCnt : '0;
    end

    buf_d      = buf_after;
    cnt_d      = cnt_after;
    state_d    = state_q;
    last_pt_d  = last_pt_q;
    clus_cnt_d = clus_cnt_q;

    if (accept) begin
      buf_d = buf_after | (BUF'(in_data) << cnt_after);
      cnt_d = cnt_after + InCnt;
    end

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d    = StFill;
          last_pt_d  = LAST_INIT;
          clus_cnt_d = '0;
        end
      end
      StFill:  ;
      StFlush: if (emit && out_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // in_last is sampled on accept; an empty buffer after it means the frame is already out.
    if (accept && in_last) state_d = (cnt_d == '0) ? StIdle : StFlush;

    if (emit) begin
      last_pt_d  = fb_pt;
      clus_cnt_d = clus_cnt_d + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      buf_q      <= '0;
      cnt_q      <= '0;
      last_pt_q  <= LAST_INIT;
      clus_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      last_pt_q  <= last_pt_d;
      clus_cnt_q <= clus_cnt_d;
    end
  end

endmodule

// File: tb/tb_qam_stream_scheduler.sv
// Scoreboard bench for qam_stream_scheduler (N=16, FORMAT=4, IN_W=32): expected clusters
// are queued with the stimulus and a negedge monitor compares every accepted cluster.
module tb_qam_stream_scheduler;

  localparam int unsigned CW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   in_data;
  logic          in_valid, in_last, in_ready;
  logic [CW-1:0] out_data;
  logic          out_valid, out_last, out_ready;
  logic [15:0]   fb_pt, last_pt, clus_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [CW-1:0] d;
    logic          l;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  qam_stream_scheduler #(
    .N(16), .W(16), .FORMAT(4), .IN_W(32), .LAST_INIT(16'h0000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_last (out_last),
    .out_ready(out_ready),
    .fb_pt    (fb_pt),
    .last_pt  (last_pt),
    .clus_cnt (clus_cnt)
  );

  // Monitor: every cluster handed over must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL cluster_unexpected: got data=%h last=%0b, required none", out_data,
                 out_last);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (out_data !== e.d || out_last !== e.l) begin
          errors++;
          $display("FAIL cluster: got data=%h last=%0b, required data=%h last=%0b", out_data,
                   out_last, e.d, e.l);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic push(input logic [CW-1:0] d, input logic l);
    exp_t e;
    e.d = d;
    e.l = l;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int n = 0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0, required 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      n++;
      @(posedge clk);
    end
    @(posedge clk);
    #1;
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 50) begin
      n++;
      @(posedge clk);
      #1;
    end
    check("wait_out_valid", 64'(out_valid), 64'd1);
  endtask

  task automatic pulse_ready();
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  logic [CW-1:0] held;

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1; fb_pt = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_last_pt", 64'(last_pt), 64'd0);
    check("rst_clus_cnt", 64'(clus_cnt), 64'd0);

    // One full cluster, frame left open
    push(64'h22222222_11111111, 1'b0);
    send(32'h11111111, 1'b0);
    send(32'h22222222, 1'b0);
    drain();
    check("t1_clus_cnt", 64'(clus_cnt), 64'd1);
    do_reset();

    // Three words: one full cluster plus a padded tail cluster
    push(64'h22222222_11111111, 1'b0);
    push(64'h00000000_33333333, 1'b1);
    send(32'h11111111, 1'b0);
    send(32'h22222222, 1'b0);
    send(32'h33333333, 1'b1);
    drain();
    check("t2_clus_cnt", 64'(clus_cnt), 64'd2);
    check("t2_idle_in_ready", 64'(in_ready), 64'd1);
    check("t2_idle_out_valid", 64'(out_valid), 64'd0);

    // last_pt tracking across emits, exact-boundary tail, reload at frame start
    out_ready = 1'b0;
    push(64'hBBBBBBBB_AAAAAAAA, 1'b0);
    push(64'hDDDDDDDD_CCCCCCCC, 1'b1);
    fb_pt = 16'h1234;
    send(32'hAAAAAAAA, 1'b0);
    send(32'hBBBBBBBB, 1'b0);
    wait_valid();
    check("t5_last_pt_init", 64'(last_pt), 64'h0);
    check("t5_clus_cnt_cleared", 64'(clus_cnt), 64'd0);
    pulse_ready();
    check("t5_last_pt_1", 64'(last_pt), 64'h1234);
    fb_pt = 16'hBEEF;
    send(32'hCCCCCCCC, 1'b0);
    send(32'hDDDDDDDD, 1'b1);
    wait_valid();
    check("t3_out_last_boundary", 64'(out_last), 64'd1);
    pulse_ready();
    check("t5_last_pt_2", 64'(last_pt), 64'hBEEF);
    check("t3_no_pad_cluster", 64'(out_valid), 64'd0);
    check("t3_clus_cnt", 64'(clus_cnt), 64'd2);
    send(32'h0F0F0F0F, 1'b0);
    check("t5_last_pt_reload", 64'(last_pt), 64'h0);
    check("t5_clus_cnt_restart", 64'(clus_cnt), 64'd0);
    do_reset();

    // Backpressure: out_ready low for 10 clocks while input keeps coming
    push(64'h0000000B_0000000A, 1'b0);
    push(64'h0000000D_0000000C, 1'b0);
    push(64'h0000000F_0000000E, 1'b1);
    out_ready = 1'b0;
    fork
      begin
        send(32'hA, 1'b0);
        send(32'hB, 1'b0);
        send(32'hC, 1'b0);
        send(32'hD, 1'b0);
        send(32'hE, 1'b0);
        send(32'hF, 1'b1);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        held = out_data;
        repeat (10) @(posedge clk);
        #1;
        check("t4_in_ready_low", 64'(in_ready), 64'd0);
        check("t4_out_valid_held", 64'(out_valid), 64'd1);
        check("t4_out_data_stable", out_data, held);
        check("t4_out_data_value", out_data, 64'h0000000B_0000000A);
        out_ready = 1'b1;
      end
    join
    drain();
    check("t4_clus_cnt", 64'(clus_cnt), 64'd3);

    // Reset mid-frame discards buffered bits
    send(32'hDEADBEEF, 1'b0);
    do_reset();
    check("t6_out_valid", 64'(out_valid), 64'd0);
    check("t6_in_ready", 64'(in_ready), 64'd1);
    check("t6_clus_cnt", 64'(clus_cnt), 64'd0);
    push(64'h55555555_44444444, 1'b1);
    send(32'h44444444, 1'b0);
    send(32'h55555555, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
